// File: rtl/pb_debounce.sv
// ---------------------------------------------------------------------------
// pb_debounce
//
// Conditions raw push-button inputs for the HPS push-button PIO and for
// fabric logic. Each bit is an independent channel that works in three steps:
//   1. A 2-flop synchroniser brings the asynchronous key pin into clk.
//   2. The sample is normalised so that 1 always means "pressed".
//   3. A stability counter changes the clean level only after
//      DEBOUNCE_CYCLES consecutive samples disagree with it.
// One-cycle press and release strobes are registered alongside the clean
// level.
//
// Parameters:
//   WIDTH           number of independent button channels
//   DEBOUNCE_CYCLES consecutive stable samples needed to change pb_clean
//   CNT_W           width of each per-channel stability counter
//   ACTIVE_LOW      1: raw key reads 0 when pressed, 0: reads 1 when pressed
//
// Ports:
//   clk         system clock (same domain as the PIO)
//   reset_n     asynchronous active-low reset
//   pb_raw      asynchronous raw key pins
//   pb_clean    debounced level, 1 = pressed
//   pb_press    one-cycle strobe when pb_clean rises
//   pb_release  one-cycle strobe when pb_clean falls
// ---------------------------------------------------------------------------
module pb_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pb_raw,
    output logic [WIDTH-1:0] pb_clean,
    output logic [WIDTH-1:0] pb_press,
    output logic [WIDTH-1:0] pb_release
);

    localparam logic             POL     = (ACTIVE_LOW != 0);
    // Idle (released) level of the raw pins, used as the synchroniser reset
    // value so that no spurious press is seen after reset.
    localparam logic [WIDTH-1:0] IDLE    = {WIDTH{POL}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] sample;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= IDLE;
            sync2_reg <= IDLE;
        end else begin
            sync1_reg <= pb_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Normalised sample: 1 = pressed regardless of board key polarity.
    assign sample = sync2_reg ^ IDLE;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             clean_reg;
            logic             clean_next;
            logic             press_reg;
            logic             press_next;
            logic             release_reg;
            logic             release_next;

            // Any sample that agrees with the current level clears the count,
            // so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples
            // flips the output. The count is cleared on the flip, so it never
            // goes past CNT_MAX and cannot wrap.
            always_comb begin
                cnt_next     = '0;
                clean_next   = clean_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                if (sample[gi] != clean_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        clean_next   = sample[gi];
                        press_next   = sample[gi];
                        release_next = ~sample[gi];
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_reg     <= '0;
                    clean_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                end else begin
                    cnt_reg     <= cnt_next;
                    clean_reg   <= clean_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                end
            end

            assign pb_clean[gi]   = clean_reg;
            assign pb_press[gi]   = press_reg;
            assign pb_release[gi] = release_reg;
        end
    endgenerate

`ifndef SYNTHESIS
    param_range_ok : assert property (@(posedge clk)
        (DEBOUNCE_CYCLES >= 2) && (longint'(DEBOUNCE_CYCLES) < (longint'(1) << CNT_W)))
        else $error("pb_debounce: DEBOUNCE_CYCLES out of range for CNT_W");
`endif

endmodule

// File: tb/tb_pb_debounce.sv
// ---------------------------------------------------------------------------
// tb_pb_debounce
//
// Two instances are driven from the same stimulus: one with active-low keys
// and one with active-high keys fed the inverted pins. Both must produce the
// same outputs. A reference model pushes the expected outputs for every clock
// into a queue; a separate monitor pops and compares one entry per cycle.
// ---------------------------------------------------------------------------
module tb_pb_debounce;

    localparam int W  = 2;
    localparam int D  = 8;
    localparam int CW = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] pb_raw  = 2'b11;
    logic [W-1:0] pb_raw_inv;
    logic [W-1:0] clean_lo, press_lo, rel_lo;
    logic [W-1:0] clean_hi, press_hi, rel_hi;

    int n_checks = 0;
    int n_fail   = 0;

    assign pb_raw_inv = ~pb_raw;

    always #5 clk = ~clk;

    pb_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW(1)) dut_lo (
        .clk        (clk),
        .reset_n    (reset_n),
        .pb_raw     (pb_raw),
        .pb_clean   (clean_lo),
        .pb_press   (press_lo),
        .pb_release (rel_lo)
    );

    pb_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(CW), .ACTIVE_LOW(0)) dut_hi (
        .clk        (clk),
        .reset_n    (reset_n),
        .pb_raw     (pb_raw_inv),
        .pb_clean   (clean_hi),
        .pb_press   (press_hi),
        .pb_release (rel_hi)
    );

    typedef struct packed {
        logic [W-1:0] clean;
        logic [W-1:0] press;
        logic [W-1:0] rel;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, req);
        end
    endtask

    // Reference model: the pressed state seen by the filter is the pin value
    // from two clocks ago. A level flips once D consecutive samples disagree
    // with it, and the flip produces a strobe in the same cycle.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_clean;
    int           run_len[W];

    always @(posedge clk) begin : model
        exp_t         e;
        logic [W-1:0] s;
        e = '0;
        if (!reset_n) begin
            hist    = {};
            hist.push_back('0);
            hist.push_back('0);
            m_clean = '0;
            for (int i = 0; i < W; i++) run_len[i] = 0;
        end else begin
            hist.push_back(~pb_raw);
            s = hist.pop_front();
            for (int i = 0; i < W; i++) begin
                if (s[i] == m_clean[i]) begin
                    run_len[i] = 0;
                end else begin
                    run_len[i] = run_len[i] + 1;
                    if (run_len[i] == D) begin
                        m_clean[i] = s[i];
                        run_len[i] = 0;
                        if (s[i]) e.press[i] = 1'b1;
                        else      e.rel[i]   = 1'b1;
                    end
                end
            end
            e.clean = m_clean;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected entry per clock, compared shortly after the edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t actual=empty required=entry", $time);
        end else begin
            e = exp_q.pop_front();
            check("clean_lo",   clean_lo, e.clean);
            check("press_lo",   press_lo, e.press);
            check("release_lo", rel_lo,   e.rel);
            check("clean_hi",   clean_hi, e.clean);
            check("press_hi",   press_hi, e.press);
            check("release_hi", rel_hi,   e.rel);
            check("press_and_release", press_lo & rel_lo, 2'b00);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asynchronous reset pulse: outputs must clear without waiting for a clock.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        check("rst_imm_clean",   clean_lo, 2'b00);
        check("rst_imm_press",   press_lo, 2'b00);
        check("rst_imm_release", rel_lo,   2'b00);
        check("rst_imm_clean_hi", clean_hi, 2'b00);
        cyc(n);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        pb_raw  = 2'b11;
        cyc(3);
        reset_n = 1'b1;
        cyc(5);

        // Reset mid-run with both keys pressed, then released pins for 50 cycles.
        pb_raw = 2'b00;
        cyc(15);
        pb_raw = 2'b11;
        cyc(2);
        do_reset(3);
        cyc(50);

        // Clean press then release on bit 0.
        pb_raw[0] = 1'b0;
        cyc(14);
        pb_raw[0] = 1'b1;
        cyc(14);

        // Bounce on bit 0: 5 pressed, 1 released, 7 pressed, then held.
        pb_raw[0] = 1'b0;
        cyc(5);
        pb_raw[0] = 1'b1;
        cyc(1);
        pb_raw[0] = 1'b0;
        cyc(7);
        cyc(12);
        pb_raw[0] = 1'b1;
        cyc(14);

        // Simultaneous press and release on both channels.
        pb_raw = 2'b00;
        cyc(14);
        pb_raw = 2'b11;
        cyc(14);

        // Key 1 held through reset.
        pb_raw[1] = 1'b0;
        cyc(14);
        do_reset(3);
        cyc(14);
        pb_raw = 2'b11;
        cyc(14);

        // Random hold lengths straddling the debounce window, with
        // occasional resets.
        repeat (300) begin
            pb_raw = W'($urandom);
            cyc($urandom_range(1, 12));
            if ($urandom_range(0, 40) == 0) do_reset($urandom_range(1, 4));
        end

        pb_raw = 2'b11;
        cyc(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
